// File: rtl/spi_slave_byte_if.sv
// SPI mode-0 responder bundle: serial pins plus the local byte handshake.
interface spi_slave_byte_if;
  logic       cs_n;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       underrun;
  logic       clr_flags;
  logic       busy;

  modport slave (
    input  cs_n, sck, mosi, tx_data, tx_load, clr_flags,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, busy
  );

  modport master (
    output cs_n, sck, mosi, tx_data, tx_load, clr_flags,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, busy
  );
endinterface

// File: rtl/spi_slave_byte.sv
// SPI mode-0 byte responder: oversamples cs_n/sck/mosi on clk, shifts a
// buffered byte out MSB first and strobes each received byte.
module spi_slave_byte #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input logic             clk,
  input logic             rst,
  spi_slave_byte_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic cs_s, sck_s, mosi_s;
  logic cs_d, sck_d;
  logic cs_fall, cs_rise, sck_rise, sck_fall;

  logic       start, stop, reload, shift, sample;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] tx_buf;
  logic       buf_full;
  logic       oe_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       underrun_q;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign cs_fall  =  cs_d  & ~cs_s;
  assign cs_rise  = ~cs_d  &  cs_s;
  assign sck_rise = ~sck_d &  sck_s;
  assign sck_fall =  sck_d & ~sck_s;

  // Synchronizer chains and one-cycle-delayed copies for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      sck_d     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      cs_d      <= cs_s;
      sck_d     <= sck_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and per-cycle datapath commands; cs rise beats any sck edge.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    stop    = 1'b0;
    reload  = 1'b0;
    shift   = 1'b0;
    sample  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          start   = 1'b1;
          reload  = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          stop    = 1'b1;
        end else if (sck_rise) begin
          sample = 1'b1;
        end else if (sck_fall) begin
          if (bit_cnt == 3'd0) reload = 1'b1;
          else                 shift  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Receive path, bit counter and output enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (start) oe_q <= 1'b1;
      if (stop)  oe_q <= 1'b0;
      if (start || stop) begin
        bit_cnt <= '0;
      end else if (sample) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data_q  <= {rx_shift, mosi_s};
          rx_valid_q <= 1'b1;
        end
      end
    end
  end

  // Transmit shifter, holding buffer and sticky underrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift   <= '0;
      tx_buf     <= '0;
      buf_full   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (shift) tx_shift <= {tx_shift[6:0], 1'b0};
      if (reload) begin
        if (buf_full) begin
          tx_shift <= tx_buf;
          buf_full <= 1'b0;
        end else begin
          tx_shift <= FILL_BYTE;
        end
      end
      // A load is accepted only into an empty buffer, so it never collides
      // with a reload that is draining a full one.
      if (bus.tx_load && !buf_full) begin
        tx_buf   <= bus.tx_data;
        buf_full <= 1'b1;
      end
      if (reload && !buf_full) underrun_q <= 1'b1;
      else if (bus.clr_flags)  underrun_q <= 1'b0;
    end
  end

  // miso is the shifter MSB gated by the pad enable: this matches loading
  // miso alongside every shift/reload and zeroing it on deselect and reset.
  assign bus.miso     = oe_q & tx_shift[7];
  assign bus.miso_oe  = oe_q;
  assign bus.tx_ready = ~buf_full;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.underrun = underrun_q;
  assign bus.busy     = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte: constant vector table, directed corner cases and
// random multi-byte frames checked against a buffer-level transmit model.
module tb_spi_slave_byte;

  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = 8;

  logic clk;
  logic rst;

  spi_slave_byte_if bus ();

  spi_slave_byte #(.SYNC_STAGES(SYNC), .FILL_BYTE(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one-deep transmit buffer and sticky underrun.
  logic [7:0] m_buf  = '0;
  bit         m_full = 1'b0;
  bit         m_und  = 1'b0;

  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (rst && bus.rx_valid) rx_q.push_back(bus.rx_data);
  end

  function automatic void m_load(input logic [7:0] d);
    if (!m_full) begin
      m_buf  = d;
      m_full = 1'b1;
    end
  endfunction

  function automatic logic [7:0] m_reload();
    if (m_full) begin
      m_full = 1'b0;
      return m_buf;
    end
    m_und = 1'b1;
    return 8'hFF;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_rx(input string nm, input logic [7:0] exp);
    logic [7:0] v;
    if (rx_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no rx_valid expected byte %h", nm, exp);
    end else begin
      v = rx_q.pop_front();
      chk(nm, v, exp);
    end
  endtask

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_byte(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
    m_load(d);
  endtask

  task automatic clr_pulse();
    bus.clr_flags = 1'b1;
    @(negedge clk);
    bus.clr_flags = 1'b0;
    m_und = 1'b0;
    wait_clks(1);
  endtask

  // One mode-0 byte; miso is sampled just before each rising sck edge.
  // On the last byte cs_n rises together with the final sck fall.
  task automatic xfer_byte(input logic [7:0] mo, input bit last, input bit do_load,
                           input logic [7:0] ld, output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      bus.mosi = mo[i];
      wait_clks(HALF);
      mi[i]   = bus.miso;
      bus.sck = 1'b1;
      if (do_load && i == 4) begin
        load_byte(ld);
        wait_clks(HALF - 1);
      end else begin
        wait_clks(HALF);
      end
      if (i == 0 && last) bus.cs_n = 1'b1;
      bus.sck = 1'b0;
    end
    if (last) wait_clks(HALF);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"},     bus.miso,     8'd0);
    chk({tag, "_miso_oe"},  bus.miso_oe,  8'd0);
    chk({tag, "_tx_ready"}, bus.tx_ready, 8'd1);
    chk({tag, "_rx_data"},  bus.rx_data,  8'h00);
    chk({tag, "_rx_valid"}, bus.rx_valid, 8'd0);
    chk({tag, "_underrun"}, bus.underrun, 8'd0);
    chk({tag, "_busy"},     bus.busy,     8'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},    bus.busy,    8'd0);
    chk({tag, "_miso_oe"}, bus.miso_oe, 8'd0);
    chk({tag, "_miso"},    bus.miso,    8'd0);
    chk({tag, "_rx_extra"}, 8'(rx_q.size()), 8'd0);
  endtask

  typedef struct {
    bit         load;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] miso;
    logic [7:0] rx;
    bit         und;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    logic [7:0] expb[3];
    logic [7:0] mos[3];
    int unsigned nb;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 8'h55, 8'hFF, 8'h55, 1'b1};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[3] = '{1'b1, 8'h81, 8'h01, 8'h81, 8'h01, 1'b0};
    vecs[4] = '{1'b0, 8'h12, 8'h80, 8'hFF, 8'h80, 1'b1};
    vecs[5] = '{1'b1, 8'hFE, 8'h7F, 8'hFE, 8'h7F, 1'b0};

    rst = 1'b0;
    bus.cs_n = 1'b1;
    bus.sck = 1'b0;
    bus.mosi = 1'b0;
    bus.tx_data = '0;
    bus.tx_load = 1'b0;
    bus.clr_flags = 1'b0;
    wait_clks(3);
    chk_reset_outputs("por");
    rst = 1'b1;
    wait_clks(4);

    // Single-byte frames from the vector table.
    for (int v = 0; v < 6; v++) begin
      clr_pulse();
      if (vecs[v].load) load_byte(vecs[v].tx);
      bus.cs_n = 1'b0;
      void'(m_reload());
      wait_clks(HALF);
      chk("tbl_busy", bus.busy, 8'd1);
      chk("tbl_miso_oe", bus.miso_oe, 8'd1);
      chk("tbl_tx_ready", bus.tx_ready, 8'd1);
      xfer_byte(vecs[v].mosi, 1'b1, 1'b0, 8'h00, got);
      chk("tbl_miso", got, vecs[v].miso);
      chk_rx("tbl_rx", vecs[v].rx);
      chk("tbl_underrun", bus.underrun, 8'(vecs[v].und));
      chk_idle("tbl");
    end

    // Two-byte frame, second byte loaded while the first shifts.
    clr_pulse();
    load_byte(8'h81);
    bus.cs_n = 1'b0;
    expb[0] = m_reload();
    wait_clks(HALF);
    xfer_byte(8'hC5, 1'b0, 1'b1, 8'h7E, got);
    chk("two_b0_miso", got, 8'h81);
    expb[1] = m_reload();
    xfer_byte(8'h1B, 1'b1, 1'b0, 8'h00, got);
    chk("two_b1_miso", got, 8'h7E);
    chk("two_b1_model", got, expb[1]);
    chk_rx("two_rx0", 8'hC5);
    chk_rx("two_rx1", 8'h1B);
    chk("two_underrun", bus.underrun, 8'd0);
    chk_idle("two");

    // Empty-buffer reload coinciding with clr_flags and tx_load.
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (SYNC) @(posedge clk);
    @(negedge clk);
    chk("same_pre_busy", bus.busy, 8'd0);
    bus.clr_flags = 1'b1;
    bus.tx_load = 1'b1;
    bus.tx_data = 8'h5A;
    @(negedge clk);
    bus.clr_flags = 1'b0;
    bus.tx_load = 1'b0;
    expb[0] = m_reload();
    m_load(8'h5A);
    chk("same_busy", bus.busy, 8'd1);
    chk("same_underrun", bus.underrun, 8'd1);
    chk("same_tx_ready", bus.tx_ready, 8'd0);
    wait_clks(HALF);
    xfer_byte(8'h69, 1'b0, 1'b0, 8'h00, got);
    chk("same_b0_miso", got, 8'hFF);
    expb[1] = m_reload();
    xfer_byte(8'h96, 1'b1, 1'b0, 8'h00, got);
    chk("same_b1_miso", got, 8'h5A);
    chk_rx("same_rx0", 8'h69);
    chk_rx("same_rx1", 8'h96);
    chk_idle("same");
    chk("clr_before", bus.underrun, 8'd1);
    clr_pulse();
    chk("clr_after", bus.underrun, 8'd0);

    // Abort after five rising edges, then a clean frame.
    load_byte(8'h33);
    bus.cs_n = 1'b0;
    void'(m_reload());
    for (int i = 0; i < 5; i++) begin
      bus.mosi = 1'(i);
      wait_clks(HALF);
      bus.sck = 1'b1;
      wait_clks(HALF);
      bus.sck = 1'b0;
    end
    wait_clks(HALF);
    bus.cs_n = 1'b1;
    wait_clks(HALF);
    chk_idle("abort");
    load_byte(8'h96);
    bus.cs_n = 1'b0;
    expb[0] = m_reload();
    wait_clks(HALF);
    xfer_byte(8'hC3, 1'b1, 1'b0, 8'h00, got);
    chk("abort_next_miso", got, 8'h96);
    chk_rx("abort_next_rx", 8'hC3);
    chk_idle("abort_next");

    // Load while the buffer is full must be ignored.
    load_byte(8'h11);
    load_byte(8'h22);
    chk("ign_tx_ready", bus.tx_ready, 8'd0);
    bus.cs_n = 1'b0;
    expb[0] = m_reload();
    wait_clks(HALF);
    xfer_byte(8'h5D, 1'b1, 1'b0, 8'h00, got);
    chk("ign_miso", got, 8'h11);
    chk("ign_model", got, expb[0]);
    chk_rx("ign_rx", 8'h5D);

    // Reset pulsed mid-byte with underrun set and the buffer full.
    bus.cs_n = 1'b0;
    wait_clks(HALF);
    load_byte(8'h44);
    for (int i = 0; i < 3; i++) begin
      bus.mosi = 1'b1;
      wait_clks(HALF);
      bus.sck = 1'b1;
      wait_clks(HALF);
      bus.sck = 1'b0;
    end
    bus.sck = 1'b1;
    wait_clks(2);
    chk("rst_pre_underrun", bus.underrun, 8'd1);
    chk("rst_pre_tx_ready", bus.tx_ready, 8'd0);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    bus.sck = 1'b0;
    bus.cs_n = 1'b1;
    wait_clks(3);
    rst = 1'b1;
    m_full = 1'b0;
    m_und = 1'b0;
    chk("midrst_no_rx", 8'(rx_q.size()), 8'd0);
    rx_q.delete();
    wait_clks(4);
    load_byte(8'hA5);
    bus.cs_n = 1'b0;
    void'(m_reload());
    wait_clks(HALF);
    xfer_byte(8'h3C, 1'b1, 1'b0, 8'h00, got);
    chk("post_rst_miso", got, 8'hA5);
    chk_rx("post_rst_rx", 8'h3C);
    chk("post_rst_underrun", bus.underrun, 8'd0);
    chk_idle("post_rst");

    // Random multi-byte frames against the buffer model.
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 1) == 1) load_byte(8'($urandom));
      if ($urandom_range(0, 3) == 0) clr_pulse();
      nb = $urandom_range(1, 3);
      bus.cs_n = 1'b0;
      expb[0] = m_reload();
      wait_clks(HALF);
      for (int unsigned k = 0; k < nb; k++) begin
        mos[k] = 8'($urandom);
        xfer_byte(mos[k], (k == nb - 1), 1'($urandom_range(0, 1)), 8'($urandom), got);
        chk("rnd_miso", got, expb[k]);
        if (k < nb - 1) expb[k+1] = m_reload();
      end
      for (int unsigned k = 0; k < nb; k++) chk_rx("rnd_rx", mos[k]);
      chk("rnd_underrun", bus.underrun, 8'(m_und));
      chk("rnd_tx_ready", bus.tx_ready, 8'(!m_full));
      chk_idle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_byte.md
Name: spi_slave_byte

Overview:
- SPI mode-0 responder (CPOL=0, CPHA=0, MSB first, 8-bit frames). It is the peer of the team's spi_master and is used for loopback verification and board-to-board links.
- It oversamples cs_n, sck and mosi on the local clk. It shifts out a buffered transmit byte on miso and presents each received byte with a one-cycle valid strobe.
- It flags transmit underrun: a byte boundary reached with no transmit byte loaded.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on cs_n, sck and mosi (minimum 2).
- FILL_BYTE, 8'hFF, byte shifted out when the transmit buffer is empty at a byte boundary.

Ports:
- clk  in  1  system clock; sck high and low phases must each last at least SYNC_STAGES+2 clk periods.
- rst  in  1  asynchronous, active-low reset.
- cs_n  in  1  chip select from master, active low, asynchronous to clk.
- sck  in  1  SPI clock from master, idle low, asynchronous to clk.
- mosi  in  1  serial data from master.
- miso  out  1  serial data to master.
- miso_oe  out  1  tri-state enable for the miso pad; high while selected.
- tx_data  in  8  byte to transmit.
- tx_load  in  1  one-cycle strobe; captures tx_data when tx_ready=1.
- tx_ready  out  1  high when the transmit buffer is empty.
- rx_data  out  8  last complete received byte.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- underrun  out  1  sticky; set when FILL_BYTE is substituted.
- clr_flags  in  1  synchronous clear of underrun.
- busy  out  1  high while in the ACTIVE state.

Behaviour:
- Reset (async, rst=0):
  - Outputs: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, underrun=0, busy=0.
  - Internals: state=IDLE, bit_cnt=0, shift registers=0, transmit buffer empty.
- Synchronization:
  - cs_n, sck and mosi each pass through SYNC_STAGES flops (cs_s, sck_s, mosi_s).
  - Edges are detected by comparing sck_s and cs_s with their values one clk earlier.
  - All actions below occur on the clk cycle after the synchronized edge is seen.
- Transmit buffer:
  - tx_load with tx_ready=1 stores tx_data; tx_ready falls the next cycle.
  - tx_load with tx_ready=0 is ignored; the buffer is not overwritten.
  - A reload (defined below) empties the buffer; tx_ready rises the next cycle.
- Reload operation:
  - If the buffer is full: tx_shift<=buffer and the buffer is emptied.
  - If the buffer is empty: tx_shift<=FILL_BYTE and underrun<=1.
  - In both cases miso<=new tx_shift[7].
  - tx_load and an empty-buffer reload in the same cycle: FILL_BYTE is sent, underrun is set, and tx_data lands in the buffer for the next byte.
- State machine, 2 states:
  - IDLE: miso_oe=0, busy=0. On cs_s falling: go to ACTIVE, bit_cnt<=0, miso_oe<=1, perform a reload.
  - ACTIVE: busy=1.
    - sck_s rising:
      - rx_shift<={rx_shift[6:0],mosi_s}; bit_cnt<=bit_cnt+1 (3 bits, wraps 7->0).
      - If bit_cnt==7: rx_data<={rx_shift[6:0],mosi_s} and rx_valid=1 for exactly one cycle.
    - sck_s falling:
      - If bit_cnt!=0: tx_shift<=tx_shift<<1 and miso<=tx_shift[6].
      - If bit_cnt==0 (byte boundary after the 8th rising edge): perform a reload.
      - The first falling edge of a frame never occurs with bit_cnt==0, because a rising edge always precedes it.
    - cs_s rising, any bit_cnt: go to IDLE, miso_oe<=0, miso<=0, bit_cnt<=0.
      - The partial received byte is discarded with no rx_valid.
      - The partially sent transmit byte is lost and the buffer is untouched.
      - Takes priority over a simultaneous sck edge.
- clr_flags clears underrun; if a set event occurs in the same cycle, set wins.
- Back-to-back frames: a new cs_n fall after a rise restarts cleanly; there is no state carry-over except buffer contents and underrun.
- Reset asserted mid-frame returns all outputs to reset values immediately; no rx_valid is generated.

Test Plan:
- Load 8'hA5, assert cs_n, clock 8 mode-0 bits of 8'h3C on mosi: miso sequence is 1,0,1,0,0,1,0,1; one rx_valid pulse with rx_data=8'h3C; tx_ready=1 after cs_n fall; underrun=0.
- Two-byte frame:
  - Setup: load 8'h81, then load 8'h7E while byte 1 shifts.
  - Response: miso carries 81 then 7E; rx_valid pulses twice, rx_data matching each mosi byte.
- Underrun:
  - Stimulus: no load, cs_n fall, 8 clocks.
  - Response: miso all 1s (FILL_BYTE), underrun=1.
  - Follow-up: clr_flags pulse clears underrun; clr_flags and a fill event in the same cycle leave underrun=1.
- Abort: cs_n rises after 5 sck rising edges -> no rx_valid, busy=0, miso_oe=0. The next full frame receives its byte correctly, with bit_cnt restarted at 0.
- tx_load while tx_ready=0 with a different value -> ignored; original buffered byte is transmitted.
- rst pulsed low mid-byte -> all outputs return to reset values asynchronously; the following frame behaves as after power-up.
